// File: rtl/idct_pkg.sv
// Shared constants, basis table, FSM state type and the round/saturate helper
// for the sequential 4x4 inverse DCT.
`timescale 1ns/1ps
package idct_pkg;

  localparam int N     = 4;
  localparam int DW    = 13;
  localparam int TW    = 17;
  localparam int CW    = 8;
  localparam int SHIFT = 6;
  localparam int ACCW  = 27;

  localparam logic signed [31:0] SMAX = 32'sd4095;
  localparam logic signed [31:0] SMIN = -32'sd4096;

  // Basis C[k][n], Q1.6 (64 == 1.0)
  localparam logic signed [CW-1:0] C [N][N] = '{
    '{ 8'sd32,  8'sd32,  8'sd32,  8'sd32},
    '{ 8'sd42,  8'sd17, -8'sd17, -8'sd42},
    '{ 8'sd32, -8'sd32, -8'sd32,  8'sd32},
    '{ 8'sd17, -8'sd42,  8'sd42, -8'sd17}
  };

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;

  function automatic logic signed [31:0] round_sat(input logic signed [31:0] acc,
                                                   input logic sat);
    logic signed [31:0] r;
    r = (acc + (32'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (sat && (r > SMAX)) return SMAX;
    else if (sat && (r < SMIN)) return SMIN;
    else return r;
  endfunction

endpackage

// File: rtl/idct_mac.sv
// Single signed multiply-accumulate with clear-on-first-term, round-shift and
// optional saturation; shared by both transform passes.
`timescale 1ns/1ps
module idct_mac
  import idct_pkg::*;
#(
  parameter int AW  = TW,
  parameter int BW  = CW,
  parameter int AXW = ACCW,
  parameter int OW  = TW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 sat_en,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] res
);

  logic signed [AW+BW-1:0] prod_s;
  logic signed [AXW-1:0]   acc_r;
  logic signed [AXW-1:0]   acc_next_s;

  assign prod_s = a * b;

  // Running sum including this cycle's product; res is valid on the last term
  always_comb begin
    if (clr) acc_next_s = AXW'(prod_s);
    else     acc_next_s = acc_r + AXW'(prod_s);
  end

  assign res = OW'(round_sat(32'(acc_next_s), sat_en));

  // Accumulator register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc_r <= '0;
    else if (en)   acc_r <= acc_next_s;
    else           acc_r <= acc_r;
  end

endmodule

// File: rtl/idct_4x4.sv
// Sequential 4x4 inverse DCT, Y = C^T * X * C, one MAC per cycle over two
// 64-cycle passes, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module idct_4x4
  import idct_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*N*N-1:0]   coef_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW*N*N-1:0]   pix_out
);

  state_e                 state_r;
  logic [5:0]             cnt_r;
  logic signed [DW-1:0]   x_r [N][N];
  logic signed [TW-1:0]   t_r [N][N];

  logic signed [TW-1:0]   mac_a_s;
  logic signed [CW-1:0]   mac_b_s;
  logic signed [TW-1:0]   mac_res_s;
  logic                   mac_en_s;
  logic                   mac_clr_s;
  logic                   mac_sat_s;
  logic [1:0]             idx_hi_s;
  logic [1:0]             idx_mid_s;
  logic [1:0]             idx_lo_s;

  // cnt = {element row, element column, innermost sum index}
  assign idx_hi_s  = cnt_r[5:4];
  assign idx_mid_s = cnt_r[3:2];
  assign idx_lo_s  = cnt_r[1:0];
  assign mac_clr_s = (idx_lo_s == 2'd0);

  // Operand selection for the shared MAC
  always_comb begin
    mac_a_s   = '0;
    mac_b_s   = '0;
    mac_en_s  = 1'b0;
    mac_sat_s = 1'b0;
    case (state_r)
      PASS1: begin
        mac_a_s  = TW'(x_r[idx_lo_s][idx_mid_s]);
        mac_b_s  = C[idx_lo_s][idx_hi_s];
        mac_en_s = 1'b1;
      end
      PASS2: begin
        mac_a_s   = t_r[idx_hi_s][idx_lo_s];
        mac_b_s   = C[idx_lo_s][idx_mid_s];
        mac_en_s  = 1'b1;
        mac_sat_s = 1'b1;
      end
      default: begin
        mac_en_s = 1'b0;
      end
    endcase
  end

  idct_mac #(
    .AW  (TW),
    .BW  (CW),
    .AXW (ACCW),
    .OW  (TW)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mac_en_s),
    .clr     (mac_clr_s),
    .sat_en  (mac_sat_s),
    .a       (mac_a_s),
    .b       (mac_b_s),
    .res     (mac_res_s)
  );

  // Control FSM, index counter, X/T/Y storage and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      pix_out   <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          x_r[r][c] <= '0;
          t_r[r][c] <= '0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                x_r[r][c] <= coef_in[(r*N+c)*DW +: DW];
              end
            end
            in_ready <= 1'b0;
            cnt_r    <= 6'd0;
            state_r  <= PASS1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        PASS1: begin
          if (idx_lo_s == 2'd3) t_r[idx_hi_s][idx_mid_s] <= mac_res_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd63) state_r <= PASS2;
        end
        PASS2: begin
          if (idx_lo_s == 2'd3) pix_out[int'(cnt_r[5:2])*DW +: DW] <= mac_res_s[DW-1:0];
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd63) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // in_ready rises one edge later, from IDLE, so a new block never lands on the handshake edge
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_4x4.sv
// Scoreboard bench for idct_4x4: directed blocks with hand-derived results,
// handshake/timing checks and random blocks against a reference model.
`timescale 1ns/1ps
module tb_idct_4x4;

  localparam int W  = 13;
  localparam int BW = W * 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] coef_in;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] pix_out;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  logic [BW-1:0] sb_q [$];

  idct_4x4 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_out   (pix_out)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] golden(input logic [BW-1:0] xb);
    int cb [4][4] = '{'{32, 32, 32, 32}, '{42, 17, -17, -42},
                      '{32, -32, -32, 32}, '{17, -42, 42, -17}};
    int x [4][4];
    int t [4][4];
    int acc;
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) x[i/4][i%4] = int'($signed(xb[i*W +: W]));
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += cb[k][n] * x[k][j];
        t[n][j] = (acc + 32) >>> 6;
      end
    for (int n = 0; n < 4; n++)
      for (int m = 0; m < 4; m++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc += t[n][j] * cb[j][m];
        acc = (acc + 32) >>> 6;
        if (acc > 4095) acc = 4095;
        if (acc < -4096) acc = -4096;
        r[(n*4+m)*W +: W] = W'(acc);
      end
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted output block with the oldest expectation
  task automatic run_monitor();
    logic [BW-1:0] exp;
    int first;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_output", out_cnt, 0);
        end else begin
          exp = sb_q.pop_front();
          first = -1;
          for (int e = 15; e >= 0; e--) if (pix_out[e*W +: W] !== exp[e*W +: W]) first = e;
          if (first < 0) check(1'b1, "block", 0, 0);
          else check(1'b0, $sformatf("block_%0d_elem_%0d", out_cnt, first),
                     int'($signed(pix_out[first*W +: W])), int'($signed(exp[first*W +: W])));
        end
      end
    end
  endtask

  task automatic send_block(input logic [BW-1:0] blk, input logic [BW-1:0] exp);
    int guard = 0;
    sb_q.push_back(exp);
    coef_in  = blk;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check(1'b0, "accept_timeout", guard, 1000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!out_valid && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!out_valid) check(1'b0, "valid_timeout", guard, 1000);
  endtask

  initial begin
    logic [BW-1:0] dc_blk, all16, zero_blk, pos_blk, neg_blk, sat_exp, rnd, snap, dummy;
    int sat_tab [16] = '{4095, -3074, 3074, 615, -3075, 625, -625, -125,
                         3075, -625, 625, 125, 615, -125, 125, 25};
    int lat, guard;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; coef_in = '0;
    dc_blk = '0; dc_blk[W-1:0] = 13'sd64;
    zero_blk = '0;
    for (int e = 0; e < 16; e++) begin
      all16[e*W +: W]   = 13'sd16;
      pos_blk[e*W +: W] = 13'sd4095;
      neg_blk[e*W +: W] = -13'sd4096;
      sat_exp[e*W +: W] = W'(sat_tab[e]);
    end

    fork run_monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    check(in_ready == 1'b0, "reset_in_ready", int'(in_ready), 0);
    check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    check(pix_out == '0, "reset_pix_out", int'(pix_out != '0), 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check(in_ready == 1'b1, "ready_after_reset", int'(in_ready), 1);

    // DC block plus accept-to-valid latency
    send_block(dc_blk, all16);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check(lat == 128, "dc_latency_edges", lat, 128);

    send_block(zero_blk, zero_blk);
    send_block(dc_blk, all16);
    send_block(pos_blk, sat_exp);
    send_block(neg_blk, golden(neg_blk));

    // Back-pressure: hold out_ready low for 10 cycles after out_valid
    guard = 0;
    while (!in_ready && guard < 1000) begin @(posedge clk); #1; guard++; end
    out_ready = 1'b0;
    send_block(pos_blk, sat_exp);
    wait_valid();
    snap = pix_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check(out_valid == 1'b1 && in_ready == 1'b0 && pix_out === snap, "bp_hold",
            int'({out_valid, in_ready, pix_out === snap}), 5);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check(out_valid == 1'b0 && in_ready == 1'b0, "bp_handshake_edge", int'({out_valid, in_ready}), 0);
    @(posedge clk); #1;
    check(in_ready == 1'b1, "bp_ready_next", int'(in_ready), 1);

    // Reset during PASS1
    send_block(dc_blk, all16);
    repeat (30) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check(out_valid == 1'b0 && in_ready == 1'b0, "midreset_handshake", int'({out_valid, in_ready}), 0);
    check(pix_out == '0, "midreset_pix_out", int'(pix_out != '0), 0);
    dummy = sb_q.pop_back();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check(in_ready == 1'b1, "midreset_ready_after", int'(in_ready), 1);
    send_block(dc_blk, all16);

    for (int b = 0; b < 200; b++) begin
      for (int e = 0; e < 16; e++) rnd[e*W +: W] = W'($urandom_range(0, 8191));
      send_block(rnd, golden(rnd));
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 2000) begin @(posedge clk); guard++; end
    check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
